// File: rtl/smg_pkg.sv
// Shared constants and helpers for the 7-segment scan display path.
// Latency: n/a (package only).
// Backpressure: n/a.
package smg_pkg;

  // Active-high segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_A    = 7'h77;
  localparam logic [6:0] SEG_B    = 7'h7C;
  localparam logic [6:0] SEG_C    = 7'h39;
  localparam logic [6:0] SEG_D    = 7'h5E;
  localparam logic [6:0] SEG_E    = 7'h79;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Position of the decimal point inside the 8-bit seg word
  localparam int DP_BIT = 7;

  // Width of the binary digit select: max(1, clog2(n))
  function automatic int sel_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/smg_scan_ctrl_if.sv
// Display bus between the lock FSM (master) and the scan controller (slave).
// Latency: n/a (wires only).
// Backpressure: none; the display accepts new data on any cycle.
interface smg_scan_ctrl_if
  import smg_pkg::*;
#(
  parameter int DIGITS = 8
);
  localparam int SEL_W = sel_width(DIGITS);

  logic [4*DIGITS-1:0] number;
  logic [DIGITS-1:0]   dp_mask;
  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   blink_mask;
  logic                all_dash;
  logic                load;
  logic [7:0]          seg;
  logic [SEL_W-1:0]    sel;
  logic                frame_start;

  modport master (
    output number, dp_mask, blank_mask, blink_mask, all_dash, load,
    input  seg, sel, frame_start
  );

  modport slave (
    input  number, dp_mask, blank_mask, blink_mask, all_dash, load,
    output seg, sel, frame_start
  );

endinterface

// File: rtl/smg_seg_decode.sv
// Hex nibble to active-high 7-segment pattern; code F renders as a dash.
// Latency: combinational, zero cycles.
// Backpressure: none.
module smg_seg_decode
  import smg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Table lookup; every code maps to a visible glyph
  always_comb begin
    pattern = SEG_DASH;
    case (code)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Multiplexed 7-segment scan: shadowed digits, dp, blank, blink, dash mode, guard.
// Latency: seg one register stage after state; load visible on seg two edges later.
// Backpressure: none; free-running scan, load accepted every cycle.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 16,
  parameter int GUARD          = 1,
  parameter int BLINK_FRAMES   = 256,
  parameter int SEL_BASE       = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  smg_scan_ctrl_if.slave bus
);

  localparam int SEL_W = sel_width(DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_END = PRE_W'(GUARD);
  localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(DIGITS - 1);
  localparam logic [SEL_W-1:0] SEL_RST   = SEL_W'(SEL_BASE);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [7:0]       INV_MASK  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [PRE_W-1:0]    pre;
  logic [SEL_W-1:0]    idx;
  logic [SEL_W-1:0]    idx_nxt;
  logic                pre_tc;
  logic                idx_tc;
  logic [BLK_W-1:0]    blk_cnt;
  logic                blink_phase;

  logic [4*DIGITS-1:0] sh_number;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic [DIGITS-1:0]   sh_blink;
  logic                sh_dash;

  logic [3:0]          digit_code [DIGITS];
  logic [6:0]          dec_pat;
  logic [7:0]          seg_raw;
  logic [7:0]          seg_q;
  logic [SEL_W-1:0]    sel_q;
  logic                fs_q;

  // Digit 0 is the leftmost (most significant) nibble
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign digit_code[g] = sh_number[4*(DIGITS-1-g) +: 4];
  end

  smg_seg_decode u_decode (
    .code    (digit_code[idx]),
    .pattern (dec_pat)
  );

  // Terminal counts and the next digit index
  always_comb begin
    pre_tc  = (pre == PRE_LAST);
    idx_tc  = (idx == IDX_LAST);
    idx_nxt = idx;
    if (pre_tc) idx_nxt = idx_tc ? '0 : idx + SEL_W'(1);
  end

  // Prescaler, digit index, select and frame pulse; sel tracks index on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      idx   <= '0;
      sel_q <= SEL_RST;
      fs_q  <= 1'b0;
    end else begin
      pre   <= pre_tc ? '0 : pre + PRE_W'(1);
      idx   <= idx_nxt;
      sel_q <= SEL_RST + idx_nxt;
      fs_q  <= pre_tc && idx_tc;
    end
  end

  // Blink phase toggles every BLINK_FRAMES completed frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (pre_tc && idx_tc) begin
      if (blk_cnt == BLK_LAST) begin
        blk_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
    end
  end

  // Shadow copy of the display request; resets to all dashes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_number <= '1;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_blink  <= '0;
      sh_dash   <= 1'b0;
    end else if (bus.load) begin
      sh_number <= bus.number;
      sh_dp     <= bus.dp_mask;
      sh_blank  <= bus.blank_mask;
      sh_blink  <= bus.blink_mask;
      sh_dash   <= bus.all_dash;
    end
  end

  // Segment priority: guard, dash mode, blank, blink, then decoded glyph with dp
  always_comb begin
    seg_raw = {1'b0, SEG_OFF};
    if (pre < GUARD_END) begin
      seg_raw = {1'b0, SEG_OFF};
    end else if (sh_dash) begin
      seg_raw = {1'b0, SEG_DASH};
    end else if (sh_blank[idx]) begin
      seg_raw = {1'b0, SEG_OFF};
    end else if (sh_blink[idx] && blink_phase) begin
      seg_raw = {1'b0, SEG_OFF};
    end else begin
      seg_raw         = {1'b0, dec_pat};
      seg_raw[DP_BIT] = sh_dp[idx];
    end
  end

  // Output register; polarity inversion also covers the off pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_q <= INV_MASK;
    else        seg_q <= seg_raw ^ INV_MASK;
  end

  assign bus.seg         = seg_q;
  assign bus.sel         = sel_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Scoreboard bench for smg_scan_ctrl: two configurations run side by side.
// Reference model derives slot, digit and blink phase from the edge count.
// Free-running; no flow control to exercise.
module tb_smg_scan_ctrl;

  localparam int S    = 4;
  localparam int G    = 1;
  localparam int BF   = 2;
  localparam int BASE = 1;

  typedef struct {
    logic [7:0] seg;
    logic [2:0] sel;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [31:0] number_v;
  logic [7:0]  dp_v, blank_v, blink_v;
  logic        dash_v, load_v;

  int cfg_d  [2] = '{8, 4};
  int cfg_al [2] = '{0, 1};
  int cfg_w  [2] = '{3, 2};

  logic [7:0] dec_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h40};

  // Model state: edges since reset release and the latched display request
  int          m_n    [2];
  logic [31:0] m_num  [2];
  logic [7:0]  m_dp   [2];
  logic [7:0]  m_bl   [2];
  logic [7:0]  m_bk   [2];
  logic        m_dash [2];

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  smg_scan_ctrl_if #(.DIGITS(8)) bus0 ();
  smg_scan_ctrl_if #(.DIGITS(4)) bus1 ();

  assign bus0.number     = number_v;
  assign bus0.dp_mask    = dp_v;
  assign bus0.blank_mask = blank_v;
  assign bus0.blink_mask = blink_v;
  assign bus0.all_dash   = dash_v;
  assign bus0.load       = load_v;

  assign bus1.number     = number_v[15:0];
  assign bus1.dp_mask    = dp_v[3:0];
  assign bus1.blank_mask = blank_v[3:0];
  assign bus1.blink_mask = blink_v[3:0];
  assign bus1.all_dash   = dash_v;
  assign bus1.load       = load_v;

  smg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(S), .GUARD(G), .BLINK_FRAMES(BF),
                  .SEL_BASE(BASE), .SEG_ACTIVE_LOW(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  smg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(S), .GUARD(G), .BLINK_FRAMES(BF),
                  .SEL_BASE(BASE), .SEG_ACTIVE_LOW(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Output expected after the edge that follows np earlier edges
  function automatic exp_t model_out(input int k, input int np);
    exp_t        e;
    int          d, p, s, idx, fr, ph, nn;
    logic [31:0] t;
    logic [7:0]  pat;
    d   = cfg_d[k];
    p   = np % S;
    s   = np / S;
    idx = s % d;
    fr  = s / d;
    ph  = (fr / BF) % 2;
    t   = m_num[k] >> (4 * (d - 1 - idx));
    if (p < G)                          pat = 8'h00;
    else if (m_dash[k])                 pat = 8'h40;
    else if (m_bl[k][idx])              pat = 8'h00;
    else if (m_bk[k][idx] && ph == 1)   pat = 8'h00;
    else pat = dec_tab[t[3:0]] | (m_dp[k][idx] ? 8'h80 : 8'h00);
    if (cfg_al[k] != 0) pat = ~pat;
    nn    = np + 1;
    e.seg = pat;
    e.sel = 3'((BASE + (nn / S) % d) % (1 << cfg_w[k]));
    e.fs  = ((nn % (S * d)) == 0);
    return e;
  endfunction

  // Reference model: push the expected response for every clock edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_n[k]    = 0;
        m_num[k]  = 32'hFFFF_FFFF;
        m_dp[k]   = 8'h00;
        m_bl[k]   = 8'h00;
        m_bk[k]   = 8'h00;
        m_dash[k] = 1'b0;
      end else begin
        if (k == 0) q0.push_back(model_out(k, m_n[k]));
        else        q1.push_back(model_out(k, m_n[k]));
        if (load_v) begin
          m_num[k]  = number_v;
          m_dp[k]   = dp_v;
          m_bl[k]   = blank_v;
          m_bk[k]   = blink_v;
          m_dash[k] = dash_v;
        end
        m_n[k] = m_n[k] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s t=%0t got seg/sel/fs=%h/%h/%h want %h/%h/%h", nm, $time,
               act[11:4], act[3:1], act[0], exp[11:4], exp[3:1], exp[0]);
    end
  endtask

  // Monitor: reset values while in reset, otherwise pop and compare each cycle
  always begin
    exp_t e;
    @(posedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      chk("reset0", {bus0.seg, bus0.sel, bus0.frame_start}, {8'h00, 3'd1, 1'b0});
      chk("reset1", {bus1.seg, 1'b0, bus1.sel, bus1.frame_start}, {8'hFF, 3'd1, 1'b0});
    end else begin
      if (q0.size() == 0) begin
        chk("q0_empty", 12'h001, 12'h000);
      end else begin
        e = q0.pop_front();
        chk("scan0", {bus0.seg, bus0.sel, bus0.frame_start}, {e.seg, e.sel, e.fs});
      end
      if (q1.size() == 0) begin
        chk("q1_empty", 12'h001, 12'h000);
      end else begin
        e = q1.pop_front();
        chk("scan1", {bus1.seg, 1'b0, bus1.sel, bus1.frame_start}, {e.seg, e.sel, e.fs});
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] num, input logic [7:0] dp,
                         input logic [7:0] bl, input logic [7:0] bk, input logic dash);
    @(negedge clk);
    number_v = num;
    dp_v     = dp;
    blank_v  = bl;
    blink_v  = bk;
    dash_v   = dash;
    load_v   = 1'b1;
    @(negedge clk);
    load_v   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    number_v = 32'h0;
    dp_v     = 8'h00;
    blank_v  = 8'h00;
    blink_v  = 8'h00;
    dash_v   = 1'b0;
    load_v   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Power-up dashes, sel and frame cadence
    run(80);

    // Mixed glyphs with one decimal point
    do_load(32'h0123ABCF, 8'h02, 8'h00, 8'h00, 1'b0);
    run(40);

    // Blank the last digit, blink the first across several half-periods
    do_load(32'h0123ABCF, 8'h02, 8'h80, 8'h01, 1'b0);
    run(200);

    // Dash mode overrides dp; live number changes without load are ignored
    do_load(32'h0123ABCF, 8'hFF, 8'h00, 8'h00, 1'b1);
    number_v = 32'h98765432;
    dp_v     = 8'h00;
    dash_v   = 1'b0;
    run(40);

    // Load coinciding with a slot change
    for (int i = 0; i < 8; i++) begin
      if ((m_n[0] % S) == S - 1) break;
      @(negedge clk);
    end
    number_v = 32'h456789DE;
    dp_v     = 8'h10;
    blank_v  = 8'h00;
    blink_v  = 8'h00;
    dash_v   = 1'b0;
    load_v   = 1'b1;
    @(negedge clk);
    load_v   = 1'b0;
    run(40);

    // Random live inputs with sparse and occasionally back-to-back loads
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      number_v = $urandom;
      dp_v     = 8'($urandom_range(0, 255));
      blank_v  = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      blink_v  = 8'($urandom_range(0, 255));
      dash_v   = ($urandom_range(0, 5) == 0);
      load_v   = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    load_v = 1'b0;

    // Reset asserted mid-slot, then scanning restarts from digit 0
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(100);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
